// File: rtl/data_mem_pkg.sv
// Shared encodings for the data-memory bridge: access kinds, FSM states and bus sizes.
// Also holds the alignment helpers used by the bridge and its lane aligner.
package data_mem_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } memOp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic [1:0] opSize(input memOp_t op);
    case (op)
      OP_LW, OP_SW:         opSize = SIZE_WORD;
      OP_LH, OP_LHU, OP_SH: opSize = SIZE_HALF;
      default:              opSize = SIZE_BYTE;
    endcase
  endfunction

  // Address bits that must be zero for a naturally aligned access of this kind.
  function automatic logic [1:0] alignMask(input memOp_t op);
    case (opSize(op))
      SIZE_WORD: alignMask = 2'b11;
      SIZE_HALF: alignMask = 2'b01;
      default:   alignMask = 2'b00;
    endcase
  endfunction

  function automatic logic isMisaligned(input memOp_t op, input logic [1:0] addrLow);
    return (addrLow & alignMask(op)) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte strobes, store-data replication, bus size and
// load-lane extraction with sign/zero extension.
module mem_align
  import data_mem_pkg::*;
(
  input  memOp_t      i_op,
  input  logic        i_write,
  input  logic [1:0]  i_addrLow,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [1:0]  o_size,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign o_size = opSize(i_op);
  assign w_byte = i_rdata[{i_addrLow, 3'b000} +: 8];
  assign w_half = i_rdata[{i_addrLow[1], 4'b0000} +: 16];

  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = i_wdata;
    case (o_size)
      SIZE_HALF: begin
        o_wdata = {2{i_wdata[15:0]}};
        if (i_write) o_wstrb = i_addrLow[1] ? 4'b1100 : 4'b0011;
      end
      SIZE_BYTE: begin
        o_wdata = {4{i_wdata[7:0]}};
        if (i_write) o_wstrb = 4'b0001 << i_addrLow;
      end
      default: begin
        if (i_write) o_wstrb = 4'b1111;
      end
    endcase
  end

  // Stores and LW pass the raw word through; the bridge only keeps it for loads.
  always_comb begin
    o_rdata = i_rdata;
    case (i_op)
      OP_LH:   o_rdata = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_rdata = {16'h0000, w_half};
      OP_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_rdata = {24'h000000, w_byte};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_bridge.sv
// M-stage to req/addr_ok/data_ok data bus bridge; stalls the pipeline until the access completes.
// Optional macro DATA_MEM_ALIGN_CHECK_EN raises adelM/adesM on misaligned accesses instead of aligning them.
module data_mem_bridge
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_enM,
  input  logic              memwriteM,
  input  logic [2:0]        mem_opM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] writedataM,
  input  logic              advanceM,
  output logic [DATA_W-1:0] readdataM,
  output logic              stallM,
  output logic              adelM,
  output logic              adesM,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  state_t            r_state, w_next;
  memOp_t            r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wr;
  logic              r_misaligned;
  logic [DATA_W-1:0] r_loadData;

  memOp_t            w_op;
  logic              w_misaligned;
  logic [ADDR_W-1:0] w_alignedAddr;
  logic              w_inReq;
  logic              w_respOk;
  logic [3:0]        w_wstrb;
  logic [DATA_W-1:0] w_wdata;
  logic [1:0]        w_size;
  logic [DATA_W-1:0] w_loadData;

  assign w_op          = memOp_t'(mem_opM);
  assign w_alignedAddr = {aluoutM[ADDR_W-1:2], aluoutM[1:0] & ~alignMask(w_op)};

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign w_misaligned = isMisaligned(w_op, aluoutM[1:0]);
`else
  assign w_misaligned = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (mem_enM)      w_next = w_misaligned ? ST_DONE : ST_REQ;
      ST_REQ:  if (data_addr_ok) w_next = data_data_ok ? ST_DONE : ST_WAIT;
      ST_WAIT: if (data_data_ok) w_next = ST_DONE;
      ST_DONE: if (advanceM)     w_next = ST_IDLE;
      default:                   w_next = ST_IDLE;
    endcase
  end

  // data_rdata is only meaningful in the cycle that completes the access.
  assign w_respOk = ((r_state == ST_REQ) && data_addr_ok && data_data_ok) ||
                    ((r_state == ST_WAIT) && data_data_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_LW;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wr         <= 1'b0;
      r_misaligned <= 1'b0;
      r_loadData   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && mem_enM) begin
        r_op         <= w_op;
        r_addr       <= w_alignedAddr;
        r_wdata      <= writedataM;
        r_wr         <= memwriteM;
        r_misaligned <= w_misaligned;
        if (w_misaligned) r_loadData <= '0;
      end
      if (w_respOk && !r_wr) r_loadData <= w_loadData;
    end
  end

  mem_align u_align (
    .i_op      (r_op),
    .i_write   (r_wr),
    .i_addrLow (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rdata   (data_rdata),
    .o_wstrb   (w_wstrb),
    .o_wdata   (w_wdata),
    .o_size    (w_size),
    .o_rdata   (w_loadData)
  );

  // Bus fields are only driven while the request is outstanding, so they read 0 otherwise.
  assign w_inReq    = (r_state == ST_REQ);
  assign data_req   = w_inReq;
  assign data_wr    = w_inReq & r_wr;
  assign data_size  = w_inReq ? w_size  : 2'b00;
  assign data_addr  = w_inReq ? r_addr  : '0;
  assign data_wstrb = w_inReq ? w_wstrb : 4'b0000;
  assign data_wdata = w_inReq ? w_wdata : '0;

  assign stallM    = mem_enM & (r_state != ST_DONE);
  assign readdataM = r_loadData;
  assign adelM     = (r_state == ST_DONE) & r_misaligned & ~r_wr;
  assign adesM     = (r_state == ST_DONE) & r_misaligned & r_wr;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge: directed vector table, corner-case sequences
// and randomized transactions checked against a transaction-level model.
module tb_data_mem_bridge;
  import data_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_enM = 1'b0;
  logic        memwriteM = 1'b0;
  logic [2:0]  mem_opM = 3'b000;
  logic [31:0] aluoutM = '0;
  logic [31:0] writedataM = '0;
  logic        advanceM = 1'b0;
  logic [31:0] readdataM;
  logic        stallM, adelM, adesM;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;

  int testCount = 0;
  int failCount = 0;

  data_mem_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .mem_enM      (mem_enM),
    .memwriteM    (memwriteM),
    .mem_opM      (mem_opM),
    .aluoutM      (aluoutM),
    .writedataM   (writedataM),
    .advanceM     (advanceM),
    .readdataM    (readdataM),
    .stallM       (stallM),
    .adelM        (adelM),
    .adesM        (adesM),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          aW;
    int          dW;
    int          hold;
    logic [31:0] expAddr;
    logic [3:0]  expStrb;
    logic [31:0] expWdata;
    logic [1:0]  expSize;
    logic [31:0] expRead;
    logic        chkRead;
    int          expStall;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; mem_enM = 1'b0; advanceM = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one M-stage access end to end, acting as the bus slave and the pipeline.
  task automatic applyStimulus(
    input  logic [2:0]  op,
    input  logic [31:0] addr, wdata, rdata,
    input  int          addrWait, dataWait, advHold,
    output int          stallCnt, reqPulses,
    output logic [31:0] busAddr, busWdata,
    output logic [3:0]  busStrb,
    output logic [1:0]  busSize,
    output logic        busWr,
    output logic [31:0] readVal,
    output logic        adel, ades, readStable, timedOut
  );
    int   cyc, reqCyc, acceptCyc;
    logic accepted, captured, prevReq, inDone;
    stallCnt = 0; reqPulses = 0; busAddr = '0; busWdata = '0; busStrb = '0;
    busSize = '0; busWr = 1'b0; readVal = '0; adel = 1'b0; ades = 1'b0;
    readStable = 1'b1; timedOut = 1'b0;
    cyc = 0; reqCyc = 0; acceptCyc = 0;
    accepted = 1'b0; captured = 1'b0; prevReq = 1'b0; inDone = 1'b0;
    @(negedge clk);
    mem_enM = 1'b1; memwriteM = (op >= 3'd5); mem_opM = op; aluoutM = addr;
    writedataM = wdata; advanceM = 1'b0;
    while (!inDone && cyc < 100) begin
      #1;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = ~rdata;
      if (!stallM) begin
        inDone = 1'b1;
      end else begin
        stallCnt++;
        if (data_req) begin
          if (!prevReq) reqPulses++;
          if (!captured) begin
            busAddr = data_addr; busWdata = data_wdata; busStrb = data_wstrb;
            busSize = data_size; busWr = data_wr; captured = 1'b1;
          end
          if (reqCyc >= addrWait) begin
            data_addr_ok = 1'b1; accepted = 1'b1; acceptCyc = cyc;
            if (dataWait == 0) begin data_data_ok = 1'b1; data_rdata = rdata; end
          end
          reqCyc++;
        end else if (accepted && (cyc - acceptCyc) == dataWait) begin
          data_data_ok = 1'b1; data_rdata = rdata;
        end
        prevReq = data_req;
        @(negedge clk);
        cyc++;
      end
    end
    if (!inDone) begin
      timedOut = 1'b1;
      doReset();
    end else begin
      readVal = readdataM; adel = adelM; ades = adesM;
      for (int h = 0; h < advHold; h++) begin
        data_data_ok = 1'b1; data_rdata = $urandom;
        @(negedge clk);
        #1;
        data_data_ok = 1'b0;
        if (readdataM !== readVal || stallM || data_req) readStable = 1'b0;
        if (adelM !== adel || adesM !== ades) readStable = 1'b0;
      end
      advanceM = 1'b1;
      @(negedge clk);
      mem_enM = 1'b0; advanceM = 1'b0;
    end
  endtask

  // Reference model: expected bus view and load result derived from address arithmetic.
  task automatic modelTxn(
    input  logic [2:0]  op,
    input  logic [31:0] addr, wdata, rdata,
    output logic        mis,
    output logic [31:0] eAddr, eWdata, eRead,
    output logic [3:0]  eStrb,
    output logic [1:0]  eSize
  );
    logic [31:0] mask, v;
    int lane;
    logic isStore;
    isStore = (op >= 3'd5);
    if (op == 3'd0 || op == 3'd5) eSize = 2'd2;
    else if (op == 3'd1 || op == 3'd2 || op == 3'd6) eSize = 2'd1;
    else eSize = 2'd0;
    mask = (eSize == 2'd2) ? 32'd3 : (eSize == 2'd1) ? 32'd1 : 32'd0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    mis = (addr & mask) != 0;
`else
    mis = 1'b0;
`endif
    eAddr = addr & ~mask;
    lane = int'(eAddr % 4);
    if (!isStore) eStrb = 4'd0;
    else if (eSize == 2'd2) eStrb = 4'd15;
    else if (eSize == 2'd1) eStrb = 4'(3 << lane);
    else eStrb = 4'(1 << lane);
    if (eSize == 2'd2) eWdata = wdata;
    else if (eSize == 2'd1) eWdata = (wdata & 32'hFFFF) * 32'h0001_0001;
    else eWdata = (wdata & 32'hFF) * 32'h0101_0101;
    v = rdata >> (8 * lane);
    case (op)
      3'd1: begin eRead = v & 32'hFFFF; if (eRead >= 32'h8000) eRead = eRead | 32'hFFFF_0000; end
      3'd2: eRead = v & 32'hFFFF;
      3'd3: begin eRead = v & 32'hFF; if (eRead >= 32'h80) eRead = eRead | 32'hFFFF_FF00; end
      3'd4: eRead = v & 32'hFF;
      default: eRead = rdata;
    endcase
  endtask

  int          stallCnt, reqPulses;
  logic [31:0] bAddr, bWdata, rVal;
  logic [3:0]  bStrb;
  logic [1:0]  bSize;
  logic        bWr, aL, aS, stable, tOut;

  initial begin
    vecs[0] = '{OP_SW,  32'h104, 32'hDEADBEEF, 32'h0,        0, 0, 0, 32'h104, 4'hF, 32'hDEADBEEF, 2'd2, 32'h0,        1'b0, 2};
    vecs[1] = '{OP_LB,  32'h103, 32'h0,        32'h80FF0011, 0, 3, 0, 32'h103, 4'h0, 32'h0,        2'd0, 32'hFFFFFF80, 1'b1, 5};
    vecs[2] = '{OP_SH,  32'h102, 32'h0000ABCD, 32'h0,        1, 1, 0, 32'h102, 4'hC, 32'hABCDABCD, 2'd1, 32'h0,        1'b0, 4};
    vecs[3] = '{OP_LHU, 32'h102, 32'h0,        32'h80FF0011, 0, 1, 3, 32'h102, 4'h0, 32'h0,        2'd1, 32'h000080FF, 1'b1, 3};
    vecs[4] = '{OP_LH,  32'h100, 32'h0,        32'h1234F00D, 2, 0, 1, 32'h100, 4'h0, 32'h0,        2'd1, 32'hFFFFF00D, 1'b1, 4};
    vecs[5] = '{OP_LBU, 32'h101, 32'h0,        32'h1234F00D, 0, 2, 0, 32'h101, 4'h0, 32'h0,        2'd0, 32'h000000F0, 1'b1, 4};
    vecs[6] = '{OP_SB,  32'h203, 32'h000000A5, 32'h0,        0, 0, 2, 32'h203, 4'h8, 32'hA5A5A5A5, 2'd0, 32'h0,        1'b0, 2};
    vecs[7] = '{OP_LW,  32'h10C, 32'h0,        32'hCAFEF00D, 1, 2, 1, 32'h10C, 4'h0, 32'h0,        2'd2, 32'hCAFEF00D, 1'b1, 5};

    doReset();
    #1;
    checkOutput("reset_req",   32'(data_req),   32'h0);
    checkOutput("reset_stall", 32'(stallM),     32'h0);
    checkOutput("reset_read",  readdataM,       32'h0);
    checkOutput("reset_strb",  32'(data_wstrb), 32'h0);
    checkOutput("reset_size",  32'(data_size),  32'h0);
    checkOutput("reset_addr",  data_addr,       32'h0);
    checkOutput("reset_adel",  32'(adelM),      32'h0);
    checkOutput("reset_ades",  32'(adesM),      32'h0);

    data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    #1;
    data_data_ok = 1'b0;
    checkOutput("idle_dataok_ignored", readdataM, 32'h0);
    checkOutput("idle_no_req", 32'(data_req), 32'h0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                    vecs[i].aW, vecs[i].dW, vecs[i].hold,
                    stallCnt, reqPulses, bAddr, bWdata, bStrb, bSize, bWr, rVal, aL, aS, stable, tOut);
      checkOutput($sformatf("vec%0d_timeout", i), 32'(tOut), 32'h0);
      checkOutput($sformatf("vec%0d_stall", i), 32'(stallCnt), 32'(vecs[i].expStall));
      checkOutput($sformatf("vec%0d_reqpulses", i), 32'(reqPulses), 32'h1);
      checkOutput($sformatf("vec%0d_addr", i), bAddr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d_strb", i), 32'(bStrb), 32'(vecs[i].expStrb));
      checkOutput($sformatf("vec%0d_size", i), 32'(bSize), 32'(vecs[i].expSize));
      checkOutput($sformatf("vec%0d_wr", i), 32'(bWr), 32'(vecs[i].op >= 3'd5));
      if (vecs[i].op >= 3'd5)
        checkOutput($sformatf("vec%0d_wdata", i), bWdata, vecs[i].expWdata);
      if (vecs[i].chkRead)
        checkOutput($sformatf("vec%0d_read", i), rVal, vecs[i].expRead);
      checkOutput($sformatf("vec%0d_held_stable", i), 32'(stable), 32'h1);
    end

    applyStimulus(OP_LW, 32'h101, 32'h0, 32'h55667788, 0, 0, 1,
                  stallCnt, reqPulses, bAddr, bWdata, bStrb, bSize, bWr, rVal, aL, aS, stable, tOut);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    checkOutput("mis_lw_req",   32'(reqPulses), 32'h0);
    checkOutput("mis_lw_stall", 32'(stallCnt),  32'h1);
    checkOutput("mis_lw_adel",  32'(aL),        32'h1);
    checkOutput("mis_lw_ades",  32'(aS),        32'h0);
    checkOutput("mis_lw_read",  rVal,           32'h0);
`else
    checkOutput("mis_lw_req",   32'(reqPulses), 32'h1);
    checkOutput("mis_lw_addr",  bAddr,          32'h100);
    checkOutput("mis_lw_adel",  32'(aL),        32'h0);
    checkOutput("mis_lw_read",  rVal,           32'h55667788);
`endif
    checkOutput("mis_lw_stable", 32'(stable), 32'h1);

    applyStimulus(OP_SH, 32'h101, 32'h00001234, 32'h0, 0, 0, 0,
                  stallCnt, reqPulses, bAddr, bWdata, bStrb, bSize, bWr, rVal, aL, aS, stable, tOut);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    checkOutput("mis_sh_req",  32'(reqPulses), 32'h0);
    checkOutput("mis_sh_ades", 32'(aS),        32'h1);
    checkOutput("mis_sh_adel", 32'(aL),        32'h0);
`else
    checkOutput("mis_sh_addr", bAddr,       32'h100);
    checkOutput("mis_sh_strb", 32'(bStrb),  32'h3);
    checkOutput("mis_sh_ades", 32'(aS),     32'h0);
`endif

    // Reset while a read is outstanding in WAIT.
    @(negedge clk);
    mem_enM = 1'b1; memwriteM = 1'b0; mem_opM = OP_LW; aluoutM = 32'h300; advanceM = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_seq_req", 32'(data_req), 32'h1);
    data_addr_ok = 1'b1;
    @(negedge clk);
    #1;
    data_addr_ok = 1'b0;
    checkOutput("rst_seq_wait_req",   32'(data_req), 32'h0);
    checkOutput("rst_seq_wait_stall", 32'(stallM),   32'h1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_seq_req_low", 32'(data_req), 32'h0);
    checkOutput("rst_seq_stall_on", 32'(stallM), 32'h1);
    mem_enM = 1'b0;
    #1;
    checkOutput("rst_seq_stall_off", 32'(stallM), 32'h0);
    mem_enM = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst_seq_idle_to_req", 32'(data_req), 32'h1);
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h11223344;
    @(negedge clk);
    #1;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    checkOutput("rst_seq_read", readdataM, 32'h11223344);
    checkOutput("rst_seq_done_stall", 32'(stallM), 32'h0);
    advanceM = 1'b1;
    @(negedge clk);
    mem_enM = 1'b0; advanceM = 1'b0;

    // Randomized transactions against the model; readdataM tracks the last load.
    doReset();
    #1;
    begin
      logic [31:0] lastRead, eAddr, eWdata, eRead, addr, wd, rd;
      logic [3:0]  eStrb;
      logic [1:0]  eSize;
      logic [2:0]  op;
      logic        mis;
      int          aW, dW, hold;
      lastRead = 32'h0;
      checkOutput("rnd_reset_read", readdataM, lastRead);
      for (int n = 0; n < 40; n++) begin
        op   = 3'($urandom_range(7));
        addr = $urandom & 32'h0000_0FFF;
        wd   = $urandom;
        rd   = $urandom;
        aW   = int'($urandom_range(2));
        dW   = int'($urandom_range(3));
        hold = int'($urandom_range(2));
        modelTxn(op, addr, wd, rd, mis, eAddr, eWdata, eRead, eStrb, eSize);
        applyStimulus(op, addr, wd, rd, aW, dW, hold,
                      stallCnt, reqPulses, bAddr, bWdata, bStrb, bSize, bWr, rVal, aL, aS, stable, tOut);
        checkOutput($sformatf("rnd%0d_timeout", n), 32'(tOut), 32'h0);
        if (mis) begin
          lastRead = 32'h0;
          checkOutput($sformatf("rnd%0d_mis_stall", n), 32'(stallCnt), 32'h1);
          checkOutput($sformatf("rnd%0d_mis_req", n), 32'(reqPulses), 32'h0);
          checkOutput($sformatf("rnd%0d_mis_adel", n), 32'(aL), 32'(op < 3'd5));
          checkOutput($sformatf("rnd%0d_mis_ades", n), 32'(aS), 32'(op >= 3'd5));
        end else begin
          if (op < 3'd5) lastRead = eRead;
          checkOutput($sformatf("rnd%0d_stall", n), 32'(stallCnt), 32'(2 + aW + dW));
          checkOutput($sformatf("rnd%0d_req", n), 32'(reqPulses), 32'h1);
          checkOutput($sformatf("rnd%0d_addr", n), bAddr, eAddr);
          checkOutput($sformatf("rnd%0d_strb", n), 32'(bStrb), 32'(eStrb));
          checkOutput($sformatf("rnd%0d_size", n), 32'(bSize), 32'(eSize));
          checkOutput($sformatf("rnd%0d_wr", n), 32'(bWr), 32'(op >= 3'd5));
          if (op >= 3'd5) checkOutput($sformatf("rnd%0d_wdata", n), bWdata, eWdata);
          checkOutput($sformatf("rnd%0d_exc", n), 32'({aL, aS}), 32'h0);
        end
        checkOutput($sformatf("rnd%0d_read", n), rVal, lastRead);
        checkOutput($sformatf("rnd%0d_stable", n), 32'(stable), 32'h1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
